// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX skid-buffered pipeline stage:
// state encoding, default widths and control-field bit positions.
package pipe_pkg;

    localparam int DATA_W_DEF = 160;
    localparam int CTRL_W_DEF = 11;
    localparam int CNT_W_DEF  = 16;

    // Encoding doubles as the occupancy count (entries held).
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_TWO   = 2'd2
    } pipeState_e;

    // ID/EX control word layout, MSB first: RegDst .. hit.
    localparam int CTRL_HIT       = 0;
    localparam int CTRL_ALUOP_LSB = 1;
    localparam int CTRL_ALUOP_MSB = 3;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_MEMWRITE  = 5;
    localparam int CTRL_MEMREAD   = 6;
    localparam int CTRL_REGWRITE  = 7;
    localparam int CTRL_MEMTOREG  = 8;
    localparam int CTRL_ALUSRC    = 9;
    localparam int CTRL_REGDST    = 10;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry register: valid flag plus control and payload.
// clear wins over load; clear drops only the valid flag so data is retained.
module pipe_slot #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [CTRL_W-1:0] ctrlIn,
    output logic              valid,
    output logic [DATA_W-1:0] dataOut,
    output logic [CTRL_W-1:0] ctrlOut
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            dataOut <= '0;
            ctrlOut <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            dataOut <= dataIn;
            ctrlOut <= ctrlIn;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage with registered in_ready, flush,
// bubble-forcing of control on empty and a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] EMPTY = PIPE_EMPTY;
    localparam logic [1:0] ONE   = PIPE_ONE;
    localparam logic [1:0] TWO   = PIPE_TWO;

    // Handshakes: a beat moves on a rising clk edge when valid & ready are both
    // high; valid never waits on ready, and in_ready is a flop so out_ready has
    // no combinational path upstream.
    logic [1:0]        state;
    logic [1:0]        nextState;
    logic              inReadyQ;
    logic              accept;
    logic              mainLoad;
    logic              mainClear;
    logic              skidLoad;
    logic              skidClear;
    logic              takeSkid;
    logic              mainValid;
    logic              skidValid;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;
    logic [DATA_W-1:0] mainDin;
    logic [CTRL_W-1:0] mainCin;
    logic [CNT_W-1:0]  stallCnt;

    assign accept = in_valid & inReadyQ;

    always_comb begin
        nextState = state;
        mainLoad  = 1'b0;
        mainClear = 1'b0;
        skidLoad  = 1'b0;
        skidClear = 1'b0;
        takeSkid  = 1'b0;
        if (flush) begin
            nextState = EMPTY;
            mainClear = 1'b1;
            skidClear = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        mainLoad  = 1'b1;
                        nextState = ONE;
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        mainLoad = 1'b1;
                    end else if (accept) begin
                        skidLoad  = 1'b1;
                        nextState = TWO;
                    end else if (out_ready) begin
                        mainClear = 1'b1;
                        nextState = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the skid entry can advance.
                    if (out_ready) begin
                        mainLoad  = 1'b1;
                        takeSkid  = 1'b1;
                        skidClear = 1'b1;
                        nextState = ONE;
                    end
                end
                default: begin
                    nextState = EMPTY;
                    mainClear = 1'b1;
                    skidClear = 1'b1;
                end
            endcase
        end
    end

    assign mainDin = takeSkid ? skidData : in_data;
    assign mainCin = takeSkid ? skidCtrl : in_ctrl;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mainLoad),
        .clear   (mainClear),
        .dataIn  (mainDin),
        .ctrlIn  (mainCin),
        .valid   (mainValid),
        .dataOut (mainData),
        .ctrlOut (mainCtrl)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skidLoad),
        .clear   (skidClear),
        .dataIn  (in_data),
        .ctrlIn  (in_ctrl),
        .valid   (skidValid),
        .dataOut (skidData),
        .ctrlOut (skidCtrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            inReadyQ <= 1'b0;
        end else begin
            state    <= nextState;
            inReadyQ <= (nextState != TWO);
        end
    end

    // Flush cycles are not counted as stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (!flush && mainValid && !out_ready && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign in_ready  = inReadyQ;
    assign out_valid = mainValid;
    assign out_data  = mainData;
    assign out_ctrl  = mainValid ? mainCtrl : '0;
    assign occupancy = state;
    assign stall_cnt = stallCnt;

    // skidValid mirrors (state == TWO) outside flush; kept as a consistency check.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (skidValid == (state == TWO));
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a vector table for single-cycle
// transitions, hand sequences for multi-cycle corners, and a payload scoreboard.
module tb_pipe_stage_skid;

    localparam int DATA_W = 160;
    localparam int CTRL_W = 11;
    localparam int CNT_W  = 16;
    localparam int PW     = CTRL_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    logic              in_ready4;
    logic              out_valid4;
    logic [DATA_W-1:0] out_data4;
    logic [CTRL_W-1:0] out_ctrl4;
    logic [1:0]        occupancy4;
    logic [3:0]        stall_cnt4;

    int errors = 0;
    int checks = 0;
    int out_cnt = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp_e;
    logic [PW-1:0] last_exp = '0;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_ctrl(out_ctrl4), .occupancy(occupancy4), .stall_cnt(stall_cnt4)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic [7:0] d);
        in_valid  = iv;
        out_ready = ordy;
        flush     = 1'b0;
        in_data   = {$urandom(), $urandom(), $urandom(), $urandom(), 24'($urandom()), d};
        in_ctrl   = CTRL_W'($urandom_range(0, 2047));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // scoreboard: mid-cycle sample of both handshakes (pop before push)
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none", out_data);
                end else begin
                    exp_e    = exp_q.pop_front();
                    last_exp = exp_e;
                    check("out_payload", 192'({out_ctrl, out_data}), 192'(exp_e));
                    out_cnt++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
        end
    end

    typedef struct {
        logic       iv;
        logic       ordy;
        logic [7:0] d;
        logic [1:0] occ;
        logic       ir;
        logic       ov;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int prev;
        int cnt0;
        logic [DATA_W-1:0] held_data;
        logic [CTRL_W-1:0] held_ctrl;

        vecs[0] = '{1'b1, 1'b1, 8'hA5, 2'd1, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 2'd0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h01, 2'd1, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 8'h02, 2'd2, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 8'h03, 2'd2, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 8'h03, 2'd1, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 8'h03, 2'd1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 2'd1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 2'd0, 1'b1, 1'b0};

        // reset state
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        step();
        step();
        check("rst_out_valid", 192'(out_valid), 192'(0));
        check("rst_out_ctrl", 192'(out_ctrl), 192'(0));
        check("rst_out_data", 192'(out_data), 192'(0));
        check("rst_occupancy", 192'(occupancy), 192'(0));
        check("rst_stall_cnt", 192'(stall_cnt), 192'(0));
        check("rst_in_ready", 192'(in_ready), 192'(0));
        rst_n = 1'b1;
        check("in_ready_before_edge", 192'(in_ready), 192'(0));
        step();
        check("in_ready_first_edge", 192'(in_ready), 192'(1));

        // single-cycle transition table
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].d);
            step();
            check($sformatf("vec%0d_occupancy", i), 192'(occupancy), 192'(vecs[i].occ));
            check($sformatf("vec%0d_in_ready", i), 192'(in_ready), 192'(vecs[i].ir));
            check($sformatf("vec%0d_out_valid", i), 192'(out_valid), 192'(vecs[i].ov));
            if (!vecs[i].ov) begin
                check($sformatf("vec%0d_bubble_ctrl", i), 192'(out_ctrl), 192'(0));
                check($sformatf("vec%0d_data_retained", i), 192'(out_data), 192'(last_exp[DATA_W-1:0]));
            end
        end

        // stream 1..8 at full throughput
        cnt0 = out_cnt;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 8'(i));
            step();
            check($sformatf("stream%0d_occupancy", i), 192'(occupancy), 192'(1));
            check($sformatf("stream%0d_out_valid", i), 192'(out_valid), 192'(1));
        end
        drive(1'b0, 1'b1, 8'h00);
        step();
        check("stream_drained", 192'(occupancy), 192'(0));
        check("stream_out_count", 192'(out_cnt - cnt0), 192'(8));

        // backpressure: 1,2 stored, 3 held upstream
        drive(1'b1, 1'b0, 8'h01);
        step();
        check("bp_occ_one", 192'(occupancy), 192'(1));
        prev = int'(stall_cnt);
        drive(1'b1, 1'b0, 8'h02);
        step();
        check("bp_occ_two", 192'(occupancy), 192'(2));
        check("bp_in_ready_low", 192'(in_ready), 192'(0));
        check("bp_stall_inc0", 192'(stall_cnt), 192'(prev + 1));
        drive(1'b1, 1'b0, 8'h03);
        for (int i = 1; i <= 3; i++) begin
            prev = int'(stall_cnt);
            step();
            check($sformatf("bp_hold%0d_occ", i), 192'(occupancy), 192'(2));
            check($sformatf("bp_hold%0d_in_ready", i), 192'(in_ready), 192'(0));
            check($sformatf("bp_hold%0d_stall_inc", i), 192'(stall_cnt), 192'(prev + 1));
        end
        cnt0 = out_cnt;
        out_ready = 1'b1;
        step();
        check("bp_release_occ", 192'(occupancy), 192'(1));
        check("bp_release_in_ready", 192'(in_ready), 192'(1));
        step();
        check("bp_accept3_occ", 192'(occupancy), 192'(1));
        in_valid = 1'b0;
        step();
        check("bp_drained", 192'(occupancy), 192'(0));
        check("bp_out_count", 192'(out_cnt - cnt0), 192'(3));

        // flush in TWO with a same-cycle input that must vanish
        drive(1'b1, 1'b0, 8'h04);
        step();
        drive(1'b1, 1'b0, 8'h05);
        step();
        check("fl_occ_two", 192'(occupancy), 192'(2));
        prev = int'(stall_cnt);
        drive(1'b1, 1'b0, 8'h09);
        flush = 1'b1;
        step();
        check("fl_out_valid", 192'(out_valid), 192'(0));
        check("fl_out_ctrl", 192'(out_ctrl), 192'(0));
        check("fl_occupancy", 192'(occupancy), 192'(0));
        check("fl_in_ready", 192'(in_ready), 192'(1));
        check("fl_stall_unchanged", 192'(stall_cnt), 192'(prev));
        drive(1'b0, 1'b1, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("fl_after%0d_out_valid", i), 192'(out_valid), 192'(0));
        end
        check("fl_queue_empty", 192'(exp_q.size()), 192'(0));

        // stall counter saturation (4-bit instance) vs. free count (16-bit)
        do_reset();
        drive(1'b1, 1'b0, 8'h07);
        held_data = in_data;
        held_ctrl = in_ctrl;
        step();
        check("sat_start", 192'(stall_cnt4), 192'(0));
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 15) check("sat_reach15", 192'(stall_cnt4), 192'(15));
        end
        check("sat_hold15", 192'(stall_cnt4), 192'(15));
        check("sat_wide_20", 192'(stall_cnt), 192'(20));
        check("sat4_occupancy", 192'(occupancy4), 192'(1));
        check("sat4_out_valid", 192'(out_valid4), 192'(1));
        check("sat4_in_ready", 192'(in_ready4), 192'(1));
        check("sat4_out_data", 192'(out_data4), 192'(held_data));
        check("sat4_out_ctrl", 192'(out_ctrl4), 192'(held_ctrl));

        // asynchronous reset while in TWO
        drive(1'b1, 1'b0, 8'h01);
        step();
        check("ar_occ_two", 192'(occupancy), 192'(2));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 192'(out_valid), 192'(0));
        check("ar_out_ctrl", 192'(out_ctrl), 192'(0));
        check("ar_out_data", 192'(out_data), 192'(0));
        check("ar_occupancy", 192'(occupancy), 192'(0));
        check("ar_in_ready", 192'(in_ready), 192'(0));
        check("ar_stall_cnt", 192'(stall_cnt), 192'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        check("ar_in_ready_pre_edge", 192'(in_ready), 192'(0));
        step();
        check("ar_in_ready_post_edge", 192'(in_ready), 192'(1));
        check("ar_out_valid_post", 192'(out_valid), 192'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
